// File: rtl/admo_alu_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// admo_alu_arbiter_pkg
// Shared definitions for the ALU and its two-port arbiter.
//   `DATA_WIDTH       datapath width (32)
//   `ALU_*            4-bit ALU operator codes
//   ALU_ARB_PORT0/1   requester indices (execute stage / address-branch unit)
// The macros are also mirrored as package localparams so that importing
// modules do not rely on macro visibility across compilation units.
// -----------------------------------------------------------------------------
`ifndef ADMO_ALU_DEFS_DONE
`define ADMO_ALU_DEFS_DONE
`define DATA_WIDTH 32
`define ALU_ADD 4'd0
`define ALU_SUB 4'd1
`define ALU_AND 4'd2
`define ALU_OR  4'd3
`define ALU_XOR 4'd4
`define ALU_SLL 4'd5
`define ALU_SRL 4'd6
`define ALU_SRA 4'd7
`define ALU_LTS 4'd8
`define ALU_LTU 4'd9
`endif

package admo_alu_arbiter_pkg;

    localparam int unsigned DATA_WIDTH = `DATA_WIDTH;

    localparam logic [3:0] ALU_ADD = `ALU_ADD;
    localparam logic [3:0] ALU_SUB = `ALU_SUB;
    localparam logic [3:0] ALU_AND = `ALU_AND;
    localparam logic [3:0] ALU_OR  = `ALU_OR;
    localparam logic [3:0] ALU_XOR = `ALU_XOR;
    localparam logic [3:0] ALU_SLL = `ALU_SLL;
    localparam logic [3:0] ALU_SRL = `ALU_SRL;
    localparam logic [3:0] ALU_SRA = `ALU_SRA;
    localparam logic [3:0] ALU_LTS = `ALU_LTS;
    localparam logic [3:0] ALU_LTU = `ALU_LTU;

    localparam logic ALU_ARB_PORT0 = 1'b0;
    localparam logic ALU_ARB_PORT1 = 1'b1;

endpackage

// File: rtl/admo_alu.sv
// -----------------------------------------------------------------------------
// admo_alu
// Purely combinational 32-bit ALU.
//   operator_i   in   4   `ALU_* operator code
//   operand_a_i  in   32  operand A
//   operand_b_i  in   32  operand B (shift amount is operand_b_i[4:0])
//   result_o     out  32  result; undefined operator codes return operand A
// -----------------------------------------------------------------------------
module admo_alu
    import admo_alu_arbiter_pkg::*;
(
    input  logic [3:0]            operator_i,
    input  logic [DATA_WIDTH-1:0] operand_a_i,
    input  logic [DATA_WIDTH-1:0] operand_b_i,
    output logic [DATA_WIDTH-1:0] result_o
);

    logic [4:0] shamt;
    assign shamt = operand_b_i[4:0];

    always_comb begin
        result_o = operand_a_i;
        case (operator_i)
            ALU_ADD: result_o = operand_a_i + operand_b_i;
            ALU_SUB: result_o = operand_a_i - operand_b_i;
            ALU_AND: result_o = operand_a_i & operand_b_i;
            ALU_OR:  result_o = operand_a_i | operand_b_i;
            ALU_XOR: result_o = operand_a_i ^ operand_b_i;
            ALU_SLL: result_o = operand_a_i << shamt;
            ALU_SRL: result_o = operand_a_i >> shamt;
            ALU_SRA: result_o = $unsigned($signed(operand_a_i) >>> shamt);
            ALU_LTS: result_o = {{(DATA_WIDTH-1){1'b0}},
                                 ($signed(operand_a_i) < $signed(operand_b_i))};
            ALU_LTU: result_o = {{(DATA_WIDTH-1){1'b0}}, (operand_a_i < operand_b_i)};
            default: result_o = operand_a_i;
        endcase
    end

endmodule

// File: rtl/admo_alu_rr_pick.sv
// -----------------------------------------------------------------------------
// admo_alu_rr_pick
// Two-way round-robin pick.
//   valid_i       in   2  request valid per port
//   last_grant_i  in   1  port granted most recently
//   enable_i      in   1  a grant may be issued this cycle
//   grant_o       out  2  one-hot grant, or zero
// -----------------------------------------------------------------------------
module admo_alu_rr_pick (
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    input  logic       enable_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        if (enable_i) begin
            case (valid_i)
                2'b01:   grant_o = 2'b01;
                2'b10:   grant_o = 2'b10;
                // Contention: the port that did not win last time goes first.
                2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
                default: grant_o = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/admo_alu_arbiter.sv
// -----------------------------------------------------------------------------
// admo_alu_arbiter
// Shares one admo_alu between the execute stage (port 0) and the
// address/branch unit (port 1). Round-robin arbitration, valid/ready request
// handshakes, single-entry result register returned to the granted port.
//   clk_i            in   1     clock
//   rstn_i           in   1     synchronous active-low reset
//   req_valid_i      in   2     request valid per port
//   req_ready_o      out  2     request accepted this cycle (one-hot or zero)
//   req_op_a_i       in   64    operand A per port, port 1 in upper half
//   req_op_b_i       in   64    operand B per port
//   req_operator_i   in   8     `ALU_* code per port, port 1 in upper nibble
//   rsp_valid_o      out  2     result valid for port k
//   rsp_ready_i      in   2     port k consumes the result
//   rsp_data_o       out  32    shared result data
//   stat_grant0_o / stat_grant1_o / stat_conflict_o  out STAT_WIDTH
//                    saturating statistics, only with ADMO_ALU_ARB_STATS_EN
// Optional feature macro: ADMO_ALU_ARB_STATS_EN
// -----------------------------------------------------------------------------
module admo_alu_arbiter
    import admo_alu_arbiter_pkg::*;
#(
    parameter int unsigned STAT_WIDTH = 16
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic [1:0]              req_valid_i,
    output logic [1:0]              req_ready_o,
    input  logic [2*DATA_WIDTH-1:0] req_op_a_i,
    input  logic [2*DATA_WIDTH-1:0] req_op_b_i,
    input  logic [7:0]              req_operator_i,
    output logic [1:0]              rsp_valid_o,
    input  logic [1:0]              rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_data_o
`ifdef ADMO_ALU_ARB_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0]   stat_grant0_o,
    output logic [STAT_WIDTH-1:0]   stat_grant1_o,
    output logic [STAT_WIDTH-1:0]   stat_conflict_o
`endif
);

    if (STAT_WIDTH < 1) begin : g_stat_width_check
        $error("admo_alu_arbiter: STAT_WIDTH must be at least 1");
    end

    localparam logic SLOT_EMPTY = 1'b0;
    localparam logic SLOT_FULL  = 1'b1;

    logic                  slot_q, slot_d;
    logic                  owner_q, owner_d;
    logic                  last_grant_q, last_grant_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic                  can_accept;
    logic [1:0]            grant;
    logic                  accept;
    logic                  grant_port;
    logic [DATA_WIDTH-1:0] alu_a, alu_b, alu_result;
    logic [3:0]            alu_op;

    // A full slot can be refilled in the same cycle its owner drains it.
    assign can_accept = (slot_q == SLOT_EMPTY) | rsp_ready_i[owner_q];

    admo_alu_rr_pick u_pick (
        .valid_i      (req_valid_i),
        .last_grant_i (last_grant_q),
        .enable_i     (can_accept),
        .grant_o      (grant)
    );

    assign req_ready_o = grant;
    assign accept      = |grant;
    assign grant_port  = grant[1];

    assign alu_a  = grant_port ? req_op_a_i[2*DATA_WIDTH-1:DATA_WIDTH] : req_op_a_i[DATA_WIDTH-1:0];
    assign alu_b  = grant_port ? req_op_b_i[2*DATA_WIDTH-1:DATA_WIDTH] : req_op_b_i[DATA_WIDTH-1:0];
    assign alu_op = grant_port ? req_operator_i[7:4] : req_operator_i[3:0];

    admo_alu u_alu (
        .operator_i  (alu_op),
        .operand_a_i (alu_a),
        .operand_b_i (alu_b),
        .result_o    (alu_result)
    );

    always_comb begin
        slot_d       = slot_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        data_d       = data_q;
        if (accept) begin
            slot_d       = SLOT_FULL;
            owner_d      = grant_port;
            last_grant_d = grant_port;
            data_d       = alu_result;
        end else if (slot_q == SLOT_FULL && rsp_ready_i[owner_q]) begin
            slot_d = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            slot_q       <= SLOT_EMPTY;
            owner_q      <= ALU_ARB_PORT0;
            last_grant_q <= ALU_ARB_PORT1;
            data_q       <= '0;
        end else begin
            slot_q       <= slot_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            data_q       <= data_d;
        end
    end

    assign rsp_valid_o[0] = (slot_q == SLOT_FULL) & (owner_q == ALU_ARB_PORT0);
    assign rsp_valid_o[1] = (slot_q == SLOT_FULL) & (owner_q == ALU_ARB_PORT1);
    assign rsp_data_o     = data_q;

`ifdef ADMO_ALU_ARB_STATS_EN
    logic [STAT_WIDTH-1:0] stat_g0_q, stat_g0_d;
    logic [STAT_WIDTH-1:0] stat_g1_q, stat_g1_d;
    logic [STAT_WIDTH-1:0] stat_cf_q, stat_cf_d;
    logic                  conflict;

    assign conflict = (&req_valid_i) & can_accept;

    // Counters stop at all-ones instead of wrapping.
    always_comb begin
        stat_g0_d = stat_g0_q;
        stat_g1_d = stat_g1_q;
        stat_cf_d = stat_cf_q;
        if (grant[0] && stat_g0_q != '1) stat_g0_d = stat_g0_q + 1'b1;
        if (grant[1] && stat_g1_q != '1) stat_g1_d = stat_g1_q + 1'b1;
        if (conflict && stat_cf_q != '1) stat_cf_d = stat_cf_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            stat_g0_q <= '0;
            stat_g1_q <= '0;
            stat_cf_q <= '0;
        end else begin
            stat_g0_q <= stat_g0_d;
            stat_g1_q <= stat_g1_d;
            stat_cf_q <= stat_cf_d;
        end
    end

    assign stat_grant0_o   = stat_g0_q;
    assign stat_grant1_o   = stat_g1_q;
    assign stat_conflict_o = stat_cf_q;
`endif

endmodule

// File: tb/tb_admo_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_admo_alu_arbiter
// Scoreboard bench: the stimulus side predicts each accept with a
// transaction-level model and queues the expected (port, data); an
// independent monitor pops and compares on every response handshake.
// -----------------------------------------------------------------------------
module tb_admo_alu_arbiter;
    import admo_alu_arbiter_pkg::*;

    localparam int unsigned SW = 4;

    logic        clk;
    logic        rstn;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_op_a;
    logic [63:0] req_op_b;
    logic [7:0]  req_operator;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_data;
`ifdef ADMO_ALU_ARB_STATS_EN
    logic [SW-1:0] stat_g0, stat_g1, stat_cf;
`endif

    admo_alu_arbiter #(.STAT_WIDTH(SW)) dut (
        .clk_i          (clk),
        .rstn_i         (rstn),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_op_a_i     (req_op_a),
        .req_op_b_i     (req_op_b),
        .req_operator_i (req_operator),
        .rsp_valid_o    (rsp_valid),
        .rsp_ready_i    (rsp_ready),
        .rsp_data_o     (rsp_data)
`ifdef ADMO_ALU_ARB_STATS_EN
        ,
        .stat_grant0_o   (stat_g0),
        .stat_grant1_o   (stat_g1),
        .stat_conflict_o (stat_cf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Transaction-level model state
    bit   m_full;
    int   m_owner;
    int   m_last;
    int   m_g0, m_g1, m_cf;
    int   sat_max = (1 << SW) - 1;

    logic [31:0] pa[2];
    logic [31:0] pb[2];
    logic [3:0]  po[2];

    function automatic logic [31:0] ref_alu(input logic [3:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] p2;
        p2 = 32'd1 << b[4:0];
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_XOR: return a ^ b;
            ALU_SLL: return a * p2;
            ALU_SRL: return a / p2;
            ALU_SRA: return a[31] ? ~((~a) / p2) : a / p2;
            ALU_LTS: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            ALU_LTU: return (a < b) ? 32'd1 : 32'd0;
            default: return a;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v < sat_max) ? v + 1 : v;
    endfunction

    // One cycle: drive at posedge+1, predict and check at negedge, return at next posedge+1.
    task automatic step(input logic [1:0] v, input logic [1:0] rr, output int win);
        bit can;
        req_valid    = v;
        rsp_ready    = rr;
        req_op_a     = {pa[1], pa[0]};
        req_op_b     = {pb[1], pb[0]};
        req_operator = {po[1], po[0]};
        @(negedge clk);
        check("rsp_valid", {30'd0, rsp_valid}, m_full ? (32'd1 << m_owner) : 32'd0);
        can = !m_full || rr[m_owner];
        win = -1;
        if (can) begin
            if (v == 2'b01)      win = 0;
            else if (v == 2'b10) win = 1;
            else if (v == 2'b11) win = 1 - m_last;
        end
        check("req_ready", {30'd0, req_ready}, (win < 0) ? 32'd0 : (32'd1 << win));
        if (v == 2'b11 && can) m_cf = sat_inc(m_cf);
        if (win == 0) m_g0 = sat_inc(m_g0);
        if (win == 1) m_g1 = sat_inc(m_g1);
        if (win >= 0) begin
            sb.push_back('{win, ref_alu(po[win], pa[win], pb[win])});
            m_full  = 1'b1;
            m_owner = win;
            m_last  = win;
        end else if (m_full && rr[m_owner]) begin
            m_full = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        @(posedge clk);
        #1;
        rstn    = 1'b1;
        m_full  = 1'b0;
        m_owner = 0;
        m_last  = 1;
        m_g0    = 0;
        m_g1    = 0;
        m_cf    = 0;
        sb.delete();
        check("reset_valid", {30'd0, rsp_valid}, 32'd0);
        check("reset_data", rsp_data, 32'd0);
    endtask

    task automatic set_port(input int k, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        po[k] = op;
        pa[k] = a;
        pb[k] = b;
    endtask

    // Monitor: compares every completed response handshake against the queue.
    always @(negedge clk) begin
        if (rstn) begin
            for (int k = 0; k < 2; k++) begin
                if (rsp_valid[k] && rsp_ready[k]) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL rsp_unexpected: port %0d data %h with empty scoreboard", k, rsp_data);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        if (e.port != k || rsp_data !== e.data) begin
                            errors++;
                            $display("FAIL rsp_data: got port %0d data %h expected port %0d data %h",
                                     k, rsp_data, e.port, e.data);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int   w;
        logic [1:0] hold;
        logic [1:0] v;
        rstn         = 1'b0;
        req_valid    = 2'b00;
        rsp_ready    = 2'b00;
        req_op_a     = '0;
        req_op_b     = '0;
        req_operator = '0;
        for (int k = 0; k < 2; k++) set_port(k, ALU_ADD, 32'd0, 32'd0);
        @(posedge clk);
        #1;
        do_reset();

`ifdef ADMO_ALU_ARB_STATS_EN
        set_port(0, ALU_SUB, 32'd10, 32'd3);
        set_port(1, ALU_XOR, 32'hF0, 32'h0F);
        for (int i = 0; i < 3; i++) step(2'b11, 2'b11, w);
        for (int i = 0; i < 2; i++) step(2'b10, 2'b11, w);
        check("stat_grant0", {28'd0, stat_g0}, 32'd2);
        check("stat_grant1", {28'd0, stat_g1}, 32'd3);
        check("stat_conflict", {28'd0, stat_cf}, 32'd3);
        step(2'b00, 2'b11, w);
        do_reset();
`endif

        // Single ADD on port 0
        set_port(0, ALU_ADD, 32'd5, 32'd7);
        step(2'b01, 2'b11, w);
        check("add_valid", {30'd0, rsp_valid}, 32'd1);
        check("add_data", rsp_data, 32'd12);
        step(2'b00, 2'b11, w);

        // Back-to-back contention alternates from port 0 after reset
        do_reset();
        set_port(0, ALU_SUB, 32'd10, 32'd3);
        set_port(1, ALU_XOR, 32'hF0, 32'h0F);
        for (int i = 0; i < 4; i++) begin
            step(2'b11, 2'b11, w);
            check("rr_valid", {30'd0, rsp_valid}, (i % 2 == 0) ? 32'd1 : 32'd2);
            check("rr_data", rsp_data, (i % 2 == 0) ? 32'd7 : 32'hFF);
        end

        // Port 1 result stalled; port 0 must wait, then refills on drain
        for (int i = 0; i < 3; i++) begin
            step(2'b01, 2'b01, w);
            check("stall_data", rsp_data, 32'hFF);
        end
        step(2'b01, 2'b10, w);
        check("refill_valid", {30'd0, rsp_valid}, 32'd1);
        check("refill_data", rsp_data, 32'd7);

        // Shift and wrap corner cases on port 0
        set_port(0, ALU_SRA, 32'h8000_0000, 32'd31);
        step(2'b01, 2'b11, w);
        check("sra", rsp_data, 32'hFFFF_FFFF);
        set_port(0, ALU_SRL, 32'h8000_0000, 32'd4);
        step(2'b01, 2'b11, w);
        check("srl", rsp_data, 32'h0800_0000);
        set_port(0, ALU_SLL, 32'd1, 32'd31);
        step(2'b01, 2'b11, w);
        check("sll", rsp_data, 32'h8000_0000);
        set_port(0, ALU_ADD, 32'hFFFF_FFFF, 32'd1);
        step(2'b01, 2'b11, w);
        check("add_wrap", rsp_data, 32'd0);
        set_port(0, 4'hF, 32'hDEAD_BEEF, 32'd1);
        step(2'b01, 2'b11, w);
        check("undef_op", rsp_data, 32'hDEAD_BEEF);

        // Reset while a held result is pending
        set_port(1, ALU_OR, 32'h1234_0000, 32'h0000_5678);
        step(2'b10, 2'b11, w);
        step(2'b00, 2'b00, w);
        do_reset();
        set_port(0, ALU_SUB, 32'd10, 32'd3);
        set_port(1, ALU_XOR, 32'hF0, 32'h0F);
        step(2'b11, 2'b11, w);
        check("post_reset_first", {30'd0, rsp_valid}, 32'd1);

        // Randomized traffic; losers keep their payload until granted
        hold = 2'b00;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
                hold = 2'b00;
            end
            for (int k = 0; k < 2; k++) begin
                if (!hold[k]) begin
                    v[k] = ($urandom_range(0, 3) != 0);
                    set_port(k, 4'($urandom_range(0, 15)), $urandom, $urandom);
                    if ($urandom_range(0, 3) == 0) pb[k] = 32'($urandom_range(0, 31));
                end
            end
            step(v, 2'($urandom_range(0, 3) == 0 ? $urandom_range(0, 3) : 3), w);
            for (int k = 0; k < 2; k++) hold[k] = v[k] && (w != k);
        end

        // Drain
        step(2'b00, 2'b11, w);
        step(2'b00, 2'b11, w);
        check("sb_empty", sb.size(), 32'd0);
`ifdef ADMO_ALU_ARB_STATS_EN
        check("stat_grant0_end", {28'd0, stat_g0}, m_g0);
        check("stat_grant1_end", {28'd0, stat_g1}, m_g1);
        check("stat_conflict_end", {28'd0, stat_cf}, m_cf);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
